// File: rtl/to_ascii_num.sv
// Streams a WIDTH-bit unsigned word out as ASCII decimal/hex characters, MSD first, one per handshake.
// Optional macro TO_ASCII_NUM_CRLF_EN appends CR LF after the last digit of every word.
module to_ascii_num #(
  parameter int WIDTH     = 16,
  parameter int RADIX     = 10,
  parameter int PAD_ZEROS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Digit count of the largest WIDTH-bit value in the chosen radix.
  function automatic int calc_digits(input int w, input int r);
    longint unsigned m;
    int              n;
    if (r == 16) return (w + 3) / 4;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    while (m != 0) begin
      n++;
      m = m / 64'd10;
    end
    return n;
  endfunction

  localparam int DIGITS = calc_digits(WIDTH, RADIX);
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [7:0] to_char(input logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_TERM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    hi_q, hi_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       buf_q [DIGITS];
  logic [3:0]       buf_d [DIGITS];
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
`ifdef TO_ASCII_NUM_CRLF_EN
  logic             lf_q, lf_d;
`endif

  logic [3:0]       digit;
  logic [WIDTH-1:0] quot;
  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    next_idx;

  assign digit     = 4'(32'(work_q) % 32'(RADIX));
  assign quot      = WIDTH'(32'(work_q) / 32'(RADIX));
  assign start_idx = (PAD_ZEROS != 0) ? IW'(DIGITS - 1) : hi_q;
  assign next_idx  = idx_q - 1'b1;

  assign in_ready  = (state_q == S_IDLE);
  assign out_data  = data_q;
  assign out_valid = valid_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef TO_ASCII_NUM_CRLF_EN
    lf_d    = lf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          hi_d    = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // One extra cycle after the last digit presents the first character from the buffer.
        if (cnt_q == CW'(DIGITS)) begin
          idx_d   = start_idx;
          data_d  = to_char(buf_q[start_idx]);
          valid_d = 1'b1;
          state_d = S_EMIT;
        end else begin
          buf_d[cnt_q[IW-1:0]] = digit;
          work_d = quot;
          if (digit != 4'd0) hi_d = cnt_q[IW-1:0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == '0) begin
`ifdef TO_ASCII_NUM_CRLF_EN
            data_d  = 8'h0D;
            lf_d    = 1'b0;
            state_d = S_TERM;
`else
            valid_d = 1'b0;
            state_d = S_IDLE;
`endif
          end else begin
            idx_d  = next_idx;
            data_d = to_char(buf_q[next_idx]);
          end
        end
      end
`ifdef TO_ASCII_NUM_CRLF_EN
      S_TERM: begin
        if (out_ready) begin
          if (!lf_q) begin
            data_d = 8'h0A;
            lf_d   = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) buf_q[i] <= '0;
`ifdef TO_ASCII_NUM_CRLF_EN
      lf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
`ifdef TO_ASCII_NUM_CRLF_EN
      lf_q    <= lf_d;
`endif
    end
  end

endmodule

// File: tb/tb_to_ascii_num.sv
// Scoreboard bench: decimal, hex and zero-padded converters fed the same words, outputs checked against a string model.
module tb_to_ascii_num;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_data = '0;
  logic [2:0]  vld = '0;
  logic [2:0]  ird;
  logic [2:0]  ov;
  logic [2:0]  ordy = 3'b111;
  logic [7:0]  od [3];

  int checks   = 0;
  int failures = 0;
  int rmode    = 0;
  int nd;

`ifdef TO_ASCII_NUM_CRLF_EN
  localparam int NT = 2;
`else
  localparam int NT = 0;
`endif

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  logic [2:0] held = '0;
  logic [7:0] hd [3];

  always #5 clk = ~clk;

  to_ascii_num #(.WIDTH(16), .RADIX(10), .PAD_ZEROS(0)) u_dec (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[0]), .in_ready(ird[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  to_ascii_num #(.WIDTH(16), .RADIX(16), .PAD_ZEROS(0)) u_hex (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[1]), .in_ready(ird[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  to_ascii_num #(.WIDTH(16), .RADIX(10), .PAD_ZEROS(1)) u_pad (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld[2]), .in_ready(ird[2]),
    .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  function automatic string model(input int unsigned v, input int unsigned radix,
                                  input bit pad, input int width);
    string       tbl = "0123456789ABCDEF";
    string       s   = "";
    int unsigned d;
    do begin
      d = v % radix;
      s = {tbl.substr(int'(d), int'(d)), s};
      v = v / radix;
    end while (v != 0);
    while (pad && s.len() < width) s = {"0", s};
    return s;
  endfunction

  function automatic void push_one(input int k, input logic [7:0] c);
    case (k)
      0:       q0.push_back(c);
      1:       q1.push_back(c);
      default: q2.push_back(c);
    endcase
  endfunction

  function automatic void push_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) push_one(k, s[i]);
`ifdef TO_ASCII_NUM_CRLF_EN
    push_one(k, 8'h0D);
    push_one(k, 8'h0A);
`endif
  endfunction

  function automatic bit pop_exp(input int k, output logic [7:0] e);
    e = 8'h00;
    case (k)
      0:       if (q0.size() != 0) begin e = q0.pop_front(); return 1'b1; end
      1:       if (q1.size() != 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // Sink readiness: held high or randomised each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) ordy[k] = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: a handshake seen here completes on the coming posedge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      held = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (held[k]) begin
          checks++;
          if (!(ov[k] && od[k] == hd[k])) begin
            failures++;
            $display("FAIL dut%0d stall_hold valid=%b data=%h want valid=1 data=%h", k, ov[k], od[k], hd[k]);
          end
        end
        held[k] = ov[k] && !ordy[k];
        hd[k]   = od[k];
        if (ov[k] && ordy[k]) begin
          checks++;
          if (!pop_exp(k, e)) begin
            failures++;
            $display("FAIL dut%0d unexpected_char got %h want none", k, od[k]);
          end else if (od[k] !== e) begin
            failures++;
            $display("FAIL dut%0d char got %h want %h", k, od[k], e);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [2:0] mask);
    logic [2:0] acc;
    int n;
    in_data = v;
    vld     = mask;
    if (mask[0]) push_str(0, model(v, 10, 1'b0, 0));
    if (mask[1]) push_str(1, model(v, 16, 1'b0, 0));
    if (mask[2]) push_str(2, model(v, 10, 1'b1, nd));
    n = 0;
    while (vld != 0 && n < 200) begin
      @(negedge clk);
      acc = vld & ird;
      @(posedge clk);
      #1;
      vld = vld & ~acc;
      n++;
    end
    checks++;
    if (vld != 0) begin
      failures++;
      $display("FAIL accept_timeout pending=%b want 000", vld);
      vld = '0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && ird == 3'b111) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (n >= 3000 || ird != 3'b111) begin
      failures++;
      $display("FAIL drain left=%0d/%0d/%0d in_ready=%b want 0/0/0 111", q0.size(), q1.size(), q2.size(), ird);
    end
  endtask

  initial begin
    int fv, fr, nv, n;
    nd = model(32'hFFFF, 10, 1'b0, 0).len();

    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || od[k] !== 8'h00) begin
        failures++;
        $display("FAIL dut%0d reset_out valid=%b data=%h want 0 00", k, ov[k], od[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ird !== 3'b111) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 111", ird);
    end

    // Latency and zero-bubble streaming on the decimal converter.
    send(16'd12345, 3'b001);
    fv = 0; fr = 0; nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (fv == 0 && ov[0]) fv = k;
      if (ov[0]) nv++;
      if (fr == 0 && ird[0]) fr = k;
    end
    checks++;
    if (fv != nd + 1) begin
      failures++;
      $display("FAIL first_valid_latency got %0d want %0d", fv, nd + 1);
    end
    checks++;
    if (nv != 5 + NT) begin
      failures++;
      $display("FAIL valid_cycles got %0d want %0d", nv, 5 + NT);
    end
    checks++;
    if (fr != nd + 1 + 5 + NT) begin
      failures++;
      $display("FAIL in_ready_return got %0d want %0d", fr, nd + 1 + 5 + NT);
    end
    drain();

    send(16'd0, 3'b111);
    send(16'd65535, 3'b111);
    send(16'd42, 3'b111);
    drain();
    rmode = 1;
    send(16'd907, 3'b111);
    send(16'hBEEF, 3'b111);
    send(16'h000A, 3'b111);
    drain();

    for (int i = 0; i < 150; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i % 10 == 0) v = 16'h0000;
      if (i % 10 == 1) v = 16'hFFFF;
      if (i % 10 == 2) v = 16'($urandom_range(0, 15));
      send(v, 3'b111);
    end
    drain();

    // Abort a word mid-emission with reset.
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    send(16'd12345, 3'b001);
    n = 0;
    while (q0.size() > 3 + NT && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || od[0] !== 8'h00 || n >= 100) begin
      failures++;
      $display("FAIL midword_reset valid=%b data=%h wait=%0d want 0 00 <100", ov[0], od[0], n);
    end
    q0.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ird !== 3'b111) begin
      failures++;
      $display("FAIL post_reset_in_ready got %b want 111", ird);
    end
    send(16'd7, 3'b001);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
